// File: rtl/idex_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its load tracker.
package idex_reg_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned REG_W  = 4;

  localparam logic [OPC_W-1:0] OPC_NOP = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_LW  = 4'b1000;

  typedef enum logic [1:0] {
    LT_IDLE = 2'd0,
    LT_WAIT = 2'd1,
    LT_DONE = 2'd2
  } lt_state_t;

  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [IMM_W-1:0]  imm;
    logic [REG_W-1:0]  wreg;
    logic              regwrite;
    logic              memwrite;
    logic              is_load;
  } idex_fields_t;

  // A bubble is a no-op that writes nothing and carries zeroed data.
  localparam idex_fields_t IDEX_BUBBLE = '{
    valid:    1'b0,
    opcode:   OPC_NOP,
    rdata1:   DATA_W'(0),
    rdata2:   DATA_W'(0),
    imm:      IMM_W'(0),
    wreg:     REG_W'(0),
    regwrite: 1'b0,
    memwrite: 1'b0,
    is_load:  1'b0
  };

endpackage

// File: rtl/idex_reg_if.sv
// Decode-side inputs, EX-side copy and hazard-unit signals of the ID/EX boundary.
interface idex_reg_if;
  import idex_reg_pkg::*;

  logic              d_valid;
  logic [OPC_W-1:0]  d_opcode;
  logic [DATA_W-1:0] d_rdata1;
  logic [DATA_W-1:0] d_rdata2;
  logic [IMM_W-1:0]  d_imm;
  logic [REG_W-1:0]  d_wreg;
  logic              d_regwrite;
  logic              d_memwrite;
  logic              d_isLoad;
  logic              idex_stall;
  logic              flush;

  logic              x_valid;
  logic [OPC_W-1:0]  x_opcode;
  logic [DATA_W-1:0] x_rdata1;
  logic [DATA_W-1:0] x_rdata2;
  logic [IMM_W-1:0]  x_imm;
  logic [REG_W-1:0]  x_wreg;
  logic              x_regwrite;
  logic              x_memwrite;
  logic              x_isLoad;
  logic              e_isLoad;
  logic [REG_W-1:0]  e_wreg;
  logic              write_done;

  // Decode stage and hazard unit side.
  modport master (
    output d_valid, d_opcode, d_rdata1, d_rdata2, d_imm, d_wreg,
           d_regwrite, d_memwrite, d_isLoad, idex_stall, flush,
    input  x_valid, x_opcode, x_rdata1, x_rdata2, x_imm, x_wreg,
           x_regwrite, x_memwrite, x_isLoad, e_isLoad, e_wreg, write_done
  );

  // Pipeline register side.
  modport slave (
    input  d_valid, d_opcode, d_rdata1, d_rdata2, d_imm, d_wreg,
           d_regwrite, d_memwrite, d_isLoad, idex_stall, flush,
    output x_valid, x_opcode, x_rdata1, x_rdata2, x_imm, x_wreg,
           x_regwrite, x_memwrite, x_isLoad, e_isLoad, e_wreg, write_done
  );

endinterface

// File: rtl/idex_reg_load_tracker.sv
// Tracks a stalled load in EX until its write-back, then pulses write_done once.
module load_tracker
  import idex_reg_pkg::*;
#(
  parameter int unsigned WB_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             idex_stall,
  input  logic             x_is_load,
  input  logic [REG_W-1:0] x_wreg,
  output logic             e_is_load,
  output logic [REG_W-1:0] e_wreg,
  output logic             write_done
);

  localparam int unsigned      CNT_W    = $clog2(WB_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WB_LAT - 1);

  lt_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] pend_wreg_q, pend_wreg_d;

  // State, counter and pending destination registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LT_IDLE;
      cnt_q       <= CNT_W'(0);
      pend_wreg_q <= REG_W'(0);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_wreg_q <= pend_wreg_d;
    end
  end

  // Next state: start on a stalled load to a real register, count down, release.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_wreg_d = pend_wreg_q;
    unique case (state_q)
      LT_IDLE: begin
        if (!flush && idex_stall && x_is_load && (x_wreg != REG_W'(0))) begin
          pend_wreg_d = x_wreg;
          cnt_d       = CNT_INIT;
          state_d     = LT_WAIT;
        end
      end
      LT_WAIT: begin
        if (flush) begin
          state_d = LT_IDLE;
        end else if (cnt_q == CNT_W'(0)) begin
          state_d = LT_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LT_DONE: state_d = LT_IDLE;
      default: state_d = LT_IDLE;
    endcase
  end

  // Outputs: pass EX through when idle, otherwise report the pending load.
  always_comb begin
    e_is_load  = x_is_load;
    e_wreg     = x_wreg;
    write_done = 1'b0;
    unique case (state_q)
      LT_WAIT: begin
        e_is_load = 1'b1;
        e_wreg    = pend_wreg_q;
      end
      LT_DONE: begin
        e_is_load  = 1'b1;
        e_wreg     = pend_wreg_q;
        write_done = !flush;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/idex_reg.sv
// ID/EX pipeline register with bubble insertion and load write-back tracking.
module idex_reg
  import idex_reg_pkg::*;
#(
  parameter int unsigned WB_LAT = 2
) (
  input logic     clk,
  input logic     rst,
  idex_reg_if.slave bus
);

  idex_fields_t d_fields;
  idex_fields_t x_d, x_q;

  assign d_fields = '{
    valid:    bus.d_valid,
    opcode:   bus.d_opcode,
    rdata1:   bus.d_rdata1,
    rdata2:   bus.d_rdata2,
    imm:      bus.d_imm,
    wreg:     bus.d_wreg,
    regwrite: bus.d_regwrite,
    memwrite: bus.d_memwrite,
    is_load:  bus.d_isLoad
  };

  // Flush and stall both insert a bubble; otherwise capture decode.
  always_comb begin
    x_d = d_fields;
    if (bus.flush || bus.idex_stall) begin
      x_d = IDEX_BUBBLE;
    end
  end

  // EX-stage copy of the decoded instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= IDEX_BUBBLE;
    end else begin
      x_q <= x_d;
    end
  end

  assign bus.x_valid    = x_q.valid;
  assign bus.x_opcode   = x_q.opcode;
  assign bus.x_rdata1   = x_q.rdata1;
  assign bus.x_rdata2   = x_q.rdata2;
  assign bus.x_imm      = x_q.imm;
  assign bus.x_wreg     = x_q.wreg;
  assign bus.x_regwrite = x_q.regwrite;
  assign bus.x_memwrite = x_q.memwrite;
  assign bus.x_isLoad   = x_q.is_load;

  load_tracker #(
    .WB_LAT(WB_LAT)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .idex_stall (bus.idex_stall),
    .x_is_load  (x_q.is_load),
    .x_wreg     (x_q.wreg),
    .e_is_load  (bus.e_isLoad),
    .e_wreg     (bus.e_wreg),
    .write_done (bus.write_done)
  );

endmodule

// File: tb/tb_idex_reg.sv
// Directed bench for the ID/EX register and its load tracker (WB_LAT = 2).
module tb_idex_reg;
  import idex_reg_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  idex_reg_if bus ();

  idex_reg #(.WB_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [3:0] op, input logic [15:0] r1,
                       input logic [15:0] r2, input logic [7:0] imm, input logic [3:0] wr,
                       input logic rw, input logic mw, input logic ld);
    bus.d_valid    = v;
    bus.d_opcode   = op;
    bus.d_rdata1   = r1;
    bus.d_rdata2   = r2;
    bus.d_imm      = imm;
    bus.d_wreg     = wr;
    bus.d_regwrite = rw;
    bus.d_memwrite = mw;
    bus.d_isLoad   = ld;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.idex_stall = 1'b1;
    bus.flush = 1'b0;
    set_d(1'b1, 4'b0011, 16'hffff, 16'heeee, 8'h77, 4'd9, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    vectors++; if (bus.x_valid !== 1'b0) begin miscompares++; $display("FAIL rst_x_valid got=%b exp=0", bus.x_valid); end
    vectors++; if (bus.x_opcode !== 4'h0) begin miscompares++; $display("FAIL rst_x_opcode got=%h exp=0", bus.x_opcode); end
    vectors++; if (bus.x_rdata1 !== 16'h0) begin miscompares++; $display("FAIL rst_x_rdata1 got=%h exp=0", bus.x_rdata1); end
    vectors++; if (bus.x_wreg !== 4'h0) begin miscompares++; $display("FAIL rst_x_wreg got=%h exp=0", bus.x_wreg); end
    vectors++; if (bus.x_isLoad !== 1'b0) begin miscompares++; $display("FAIL rst_x_isLoad got=%b exp=0", bus.x_isLoad); end
    vectors++; if (bus.e_isLoad !== 1'b0) begin miscompares++; $display("FAIL rst_e_isLoad got=%b exp=0", bus.e_isLoad); end
    vectors++; if (bus.e_wreg !== 4'h0) begin miscompares++; $display("FAIL rst_e_wreg got=%h exp=0", bus.e_wreg); end
    vectors++; if (bus.write_done !== 1'b0) begin miscompares++; $display("FAIL rst_write_done got=%b exp=0", bus.write_done); end
    rst = 1'b0;
    bus.idex_stall = 1'b0;
  endtask

  task automatic test_plain_capture();
    set_d(1'b1, 4'b0001, 16'h1234, 16'habcd, 8'h5a, 4'd3, 1'b1, 1'b0, 1'b0);
    tick();
    vectors++; if (bus.x_valid !== 1'b1) begin miscompares++; $display("FAIL cap_x_valid got=%b exp=1", bus.x_valid); end
    vectors++; if (bus.x_opcode !== 4'b0001) begin miscompares++; $display("FAIL cap_x_opcode got=%h exp=1", bus.x_opcode); end
    vectors++; if (bus.x_rdata1 !== 16'h1234) begin miscompares++; $display("FAIL cap_x_rdata1 got=%h exp=1234", bus.x_rdata1); end
    vectors++; if (bus.x_rdata2 !== 16'habcd) begin miscompares++; $display("FAIL cap_x_rdata2 got=%h exp=abcd", bus.x_rdata2); end
    vectors++; if (bus.x_imm !== 8'h5a) begin miscompares++; $display("FAIL cap_x_imm got=%h exp=5a", bus.x_imm); end
    vectors++; if (bus.x_wreg !== 4'd3) begin miscompares++; $display("FAIL cap_x_wreg got=%h exp=3", bus.x_wreg); end
    vectors++; if (bus.x_regwrite !== 1'b1) begin miscompares++; $display("FAIL cap_x_regwrite got=%b exp=1", bus.x_regwrite); end
    vectors++; if (bus.e_wreg !== 4'd3) begin miscompares++; $display("FAIL cap_e_wreg got=%h exp=3", bus.e_wreg); end
    set_d(1'b1, 4'b0100, 16'h00f0, 16'h0f00, 8'h81, 4'd12, 1'b0, 1'b1, 1'b0);
    tick();
    vectors++; if (bus.x_memwrite !== 1'b1) begin miscompares++; $display("FAIL cap2_x_memwrite got=%b exp=1", bus.x_memwrite); end
    vectors++; if (bus.x_regwrite !== 1'b0) begin miscompares++; $display("FAIL cap2_x_regwrite got=%b exp=0", bus.x_regwrite); end
    vectors++; if (bus.x_rdata2 !== 16'h0f00) begin miscompares++; $display("FAIL cap2_x_rdata2 got=%h exp=0f00", bus.x_rdata2); end
    vectors++; if (bus.x_imm !== 8'h81) begin miscompares++; $display("FAIL cap2_x_imm got=%h exp=81", bus.x_imm); end
  endtask

  task automatic test_load_use();
    set_d(1'b1, OPC_LW, 16'h0100, 16'h0000, 8'h04, 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    vectors++; if (bus.e_wreg !== 4'd5 || bus.e_isLoad !== 1'b1) begin miscompares++; $display("FAIL lu_detect e_wreg=%h e_isLoad=%b exp 5/1", bus.e_wreg, bus.e_isLoad); end
    vectors++; if (bus.write_done !== 1'b0) begin miscompares++; $display("FAIL lu_detect_wd got=%b exp=0", bus.write_done); end
    set_d(1'b1, 4'b0010, 16'h0005, 16'h0006, 8'h00, 4'd6, 1'b1, 1'b0, 1'b0);
    bus.idex_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++; if (bus.e_wreg !== 4'd5 || bus.e_isLoad !== 1'b1) begin miscompares++; $display("FAIL lu_track c=%0d e_wreg=%h e_isLoad=%b exp 5/1", c, bus.e_wreg, bus.e_isLoad); end
      vectors++; if (bus.write_done !== (c == 3)) begin miscompares++; $display("FAIL lu_wd c=%0d got=%b exp=%b", c, bus.write_done, (c == 3)); end
      vectors++; if (bus.x_valid !== 1'b0 || bus.x_opcode !== OPC_NOP) begin miscompares++; $display("FAIL lu_bubble c=%0d x_valid=%b x_opcode=%h exp 0/0", c, bus.x_valid, bus.x_opcode); end
    end
    bus.idex_stall = 1'b0;
    tick();
    vectors++; if (bus.x_opcode !== 4'b0010 || bus.x_wreg !== 4'd6) begin miscompares++; $display("FAIL lu_dep x_opcode=%h x_wreg=%h exp 2/6", bus.x_opcode, bus.x_wreg); end
    vectors++; if (bus.write_done !== 1'b0 || bus.e_isLoad !== 1'b0) begin miscompares++; $display("FAIL lu_after wd=%b e_isLoad=%b exp 0/0", bus.write_done, bus.e_isLoad); end
  endtask

  task automatic test_flush_in_wait();
    int pulses;
    pulses = 0;
    set_d(1'b1, OPC_LW, 16'h0200, 16'h0000, 8'h08, 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    set_d(1'b1, 4'b0010, 16'h0001, 16'h0002, 8'h00, 4'd1, 1'b1, 1'b0, 1'b0);
    bus.idex_stall = 1'b1;
    tick();
    vectors++; if (bus.e_isLoad !== 1'b1 || bus.e_wreg !== 4'd5) begin miscompares++; $display("FAIL fl_wait e_isLoad=%b e_wreg=%h exp 1/5", bus.e_isLoad, bus.e_wreg); end
    bus.flush = 1'b1;
    tick();
    pulses += int'(bus.write_done);
    bus.flush = 1'b0;
    bus.idex_stall = 1'b0;
    vectors++; if (bus.e_isLoad !== 1'b0) begin miscompares++; $display("FAIL fl_idle e_isLoad got=%b exp=0", bus.e_isLoad); end
    vectors++; if (bus.x_valid !== 1'b0 || bus.x_wreg !== 4'd0) begin miscompares++; $display("FAIL fl_bubble x_valid=%b x_wreg=%h exp 0/0", bus.x_valid, bus.x_wreg); end
    for (int c = 0; c < 4; c++) begin
      tick();
      pulses += int'(bus.write_done);
    end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL fl_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_load_r0();
    set_d(1'b1, OPC_LW, 16'h0300, 16'h0000, 8'h0c, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    set_d(1'b1, 4'b0010, 16'h0000, 16'h0000, 8'h00, 4'd2, 1'b1, 1'b0, 1'b0);
    bus.idex_stall = 1'b1;
    tick();
    bus.idex_stall = 1'b0;
    vectors++; if (bus.x_valid !== 1'b0 || bus.x_isLoad !== 1'b0) begin miscompares++; $display("FAIL r0_bubble x_valid=%b x_isLoad=%b exp 0/0", bus.x_valid, bus.x_isLoad); end
    vectors++; if (bus.e_isLoad !== 1'b0 || bus.write_done !== 1'b0) begin miscompares++; $display("FAIL r0_idle e_isLoad=%b wd=%b exp 0/0", bus.e_isLoad, bus.write_done); end
    tick();
    vectors++; if (bus.write_done !== 1'b0 || bus.x_wreg !== 4'd2) begin miscompares++; $display("FAIL r0_after wd=%b x_wreg=%h exp 0/2", bus.write_done, bus.x_wreg); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    set_d(1'b1, OPC_LW, 16'h0400, 16'h0000, 8'h10, 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    set_d(1'b1, OPC_LW, 16'h0500, 16'h0000, 8'h14, 4'd7, 1'b1, 1'b0, 1'b1);
    bus.idex_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      pulses += int'(bus.write_done);
      vectors++; if (bus.e_wreg !== 4'd5 || bus.write_done !== (c == 3)) begin miscompares++; $display("FAIL b2b_a c=%0d e_wreg=%h wd=%b exp 5/%b", c, bus.e_wreg, bus.write_done, (c == 3)); end
    end
    bus.idex_stall = 1'b0;
    tick();
    pulses += int'(bus.write_done);
    vectors++; if (bus.x_isLoad !== 1'b1 || bus.x_wreg !== 4'd7) begin miscompares++; $display("FAIL b2b_cap x_isLoad=%b x_wreg=%h exp 1/7", bus.x_isLoad, bus.x_wreg); end
    vectors++; if (bus.e_wreg !== 4'd7 || bus.write_done !== 1'b0) begin miscompares++; $display("FAIL b2b_detect e_wreg=%h wd=%b exp 7/0", bus.e_wreg, bus.write_done); end
    set_d(1'b1, 4'b0010, 16'h0007, 16'h0001, 8'h00, 4'd8, 1'b1, 1'b0, 1'b0);
    bus.idex_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      pulses += int'(bus.write_done);
      vectors++; if (bus.e_wreg !== 4'd7 || bus.e_isLoad !== 1'b1 || bus.write_done !== (c == 3)) begin miscompares++; $display("FAIL b2b_b c=%0d e_wreg=%h e_isLoad=%b wd=%b exp 7/1/%b", c, bus.e_wreg, bus.e_isLoad, bus.write_done, (c == 3)); end
    end
    bus.idex_stall = 1'b0;
    tick();
    pulses += int'(bus.write_done);
    vectors++; if (bus.x_wreg !== 4'd8 || bus.x_opcode !== 4'b0010) begin miscompares++; $display("FAIL b2b_dep x_wreg=%h x_opcode=%h exp 8/2", bus.x_wreg, bus.x_opcode); end
    vectors++; if (pulses != 2) begin miscompares++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_reset_mid_wait();
    set_d(1'b1, OPC_LW, 16'h0600, 16'h0000, 8'h18, 4'd5, 1'b1, 1'b0, 1'b1);
    tick();
    bus.idex_stall = 1'b1;
    tick();
    vectors++; if (bus.e_isLoad !== 1'b1 || bus.e_wreg !== 4'd5) begin miscompares++; $display("FAIL rw_wait e_isLoad=%b e_wreg=%h exp 1/5", bus.e_isLoad, bus.e_wreg); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.idex_stall = 1'b0;
    set_d(1'b0, OPC_NOP, 16'h0000, 16'h0000, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    vectors++; if (bus.x_valid !== 1'b0 || bus.write_done !== 1'b0) begin miscompares++; $display("FAIL rw_rst x_valid=%b wd=%b exp 0/0", bus.x_valid, bus.write_done); end
    vectors++; if (bus.e_isLoad !== 1'b0 || bus.e_wreg !== 4'd0) begin miscompares++; $display("FAIL rw_idle e_isLoad=%b e_wreg=%h exp 0/0", bus.e_isLoad, bus.e_wreg); end
    tick();
    vectors++; if (bus.write_done !== 1'b0 || bus.e_isLoad !== 1'b0) begin miscompares++; $display("FAIL rw_after wd=%b e_isLoad=%b exp 0/0", bus.write_done, bus.e_isLoad); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.idex_stall = 1'b0;
    bus.flush = 1'b0;
    set_d(1'b0, OPC_NOP, 16'h0000, 16'h0000, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_plain_capture();
    test_load_use();
    test_flush_in_wait();
    test_load_r0();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/idex_reg.md
IDEX_REG -- requirements
Module: idex_reg

Interface
REQ-001 SHALL have parameter WB_LAT, default 2, cycles from a load in EX to its register write-back.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port d_valid  in  1  decode holds a real instruction.
REQ-005 SHALL have port d_opcode  in  4  decode opcode.
REQ-006 SHALL have port d_rdata1/d_rdata2  in  16 each  register-file read data.
REQ-007 SHALL have port d_imm  in  8  immediate/offset field.
REQ-008 SHALL have port d_wreg  in  4  destination register.
REQ-009 SHALL have port d_regwrite, d_memwrite, d_isLoad  in  1 each  decoded controls.
REQ-010 SHALL have port idex_stall  in  1  load-use stall request from the hazard unit.
REQ-011 SHALL have port flush  in  1  taken-branch kill of decode.
REQ-012 SHALL have ports x_valid, x_opcode, x_rdata1, x_rdata2, x_imm, x_wreg, x_regwrite, x_memwrite, x_isLoad  out  widths as the d_* inputs  registered EX-stage copy.
REQ-013 SHALL have port e_isLoad  out  1  load-in-EX indication to the hazard unit.
REQ-014 SHALL have port e_wreg  out  4  destination of that load.
REQ-015 SHALL have port write_done  out  1  one-cycle stall-release pulse to the hazard unit.

Function
REQ-016 Pipeline register update priority SHALL be rst > flush > idex_stall > capture.
REQ-017 Bubble SHALL mean x_valid=0, x_opcode=4'b0000, x_wreg=0, x_regwrite=x_memwrite=x_isLoad=0, data/imm fields 0.
REQ-018 On flush or idex_stall the register SHALL load a bubble; otherwise it SHALL capture all d_* fields (one-cycle latency).
REQ-019 Load tracker FSM states SHALL be IDLE, WAIT, DONE, with a down-counter of width clog2(WB_LAT)+1.
REQ-020 IDLE: e_isLoad=x_isLoad, e_wreg=x_wreg; if idex_stall=1 and x_isLoad=1 and x_wreg!=0, SHALL latch pend_wreg=x_wreg, load counter=WB_LAT-1, go WAIT.
REQ-021 IDLE with idex_stall=1 but no qualifying load in EX SHALL stay IDLE (bubble still inserted).
REQ-022 WAIT: e_isLoad=1, e_wreg=pend_wreg; counter==0 -> DONE, else decrement.
REQ-023 DONE: write_done=1 for exactly one cycle, e_isLoad=1, e_wreg=pend_wreg; unconditional -> IDLE.
REQ-024 write_done SHALL be 0 in every state other than DONE.
REQ-025 flush in WAIT or DONE SHALL abort to IDLE next cycle with no write_done pulse.
REQ-026 With WB_LAT=2 a load-use hazard SHALL yield exactly three stalled cycles (detect, WAIT, WAIT) and capture of the dependent instruction in the DONE cycle.
REQ-027 Loads with x_wreg=0 SHALL never start tracking.

Reset
REQ-028 rst SHALL force a bubble into all x_* outputs, FSM to IDLE, counter and pend_wreg to 0, write_done to 0, e_isLoad to 0, e_wreg to 0, on the next rising edge, overriding any in-progress stall.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, opcode constants (NOP=4'b0000, LW=4'b1000) and the bubble field values.
REQ-030 The FSM and counter SHALL be a sub-module named load_tracker; idex_reg instantiates it alongside the pipeline register.

Verification
REQ-031 Reset mid-WAIT: assert rst -> next cycle state IDLE, x_valid=0, write_done=0, e_isLoad=0.
REQ-032 Plain capture: d_opcode=4'b0001, d_rdata1=16'h1234, d_wreg=3, no stall -> next cycle x_opcode=4'b0001, x_rdata1=16'h1234, x_wreg=3.
REQ-033 Load-use: LW to r5 in EX, idex_stall=1 held until write_done -> e_wreg=5 for 4 cycles, write_done=1 only on the 4th, three bubbles in EX.
REQ-034 Flush in WAIT: flush=1 during first WAIT cycle -> IDLE next cycle, write_done never pulses, x_* bubble.
REQ-035 Load to r0 with idex_stall=1 -> FSM stays IDLE, write_done=0, bubble inserted.
REQ-036 Back-to-back: second LW to r7 captured the cycle after DONE -> new tracking cycle with e_wreg=7, one write_done pulse per stall.
